// File: rtl/search_latch_tx.sv
// search_latch_tx: MSB-first serialiser with frame strobe and even parity.
// Every output is a flop, so the receiving latches see clean edge-launched data.
module search_latch_tx #(
   parameter int WIDTH     = 8,
   parameter bit PARITY_EN = 1'b1,
   parameter int GAP       = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             ser_out,
   output logic             ser_frame,
   output logic             ser_en,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_PAR,
      S_GAP
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic [3:0]       gapcnt_q, gapcnt_d;
   logic             par_q, par_d;
   logic             sout_q, sout_d;
   logic             sfr_q, sfr_d;
   logic             sen_q, sen_d;
   logic             done_q, done_d;
   state_e           post_frame;

   assign post_frame = (GAP == 0) ? S_IDLE : S_GAP;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      gapcnt_d = gapcnt_q;
      par_d    = par_q;
      done_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (tx_valid) begin
               state_d  = S_SHIFT;
               shreg_d  = tx_data;
               bitcnt_d = LAST;
               par_d    = ^tx_data;
            end
         end
         S_SHIFT: begin
            shreg_d = shreg_q << 1;
            if (bitcnt_q == '0) begin
               gapcnt_d = GAP_LD;
               if (PARITY_EN) begin
                  state_d = S_PAR;
               end else begin
                  state_d = post_frame;
                  done_d  = 1'b1;
               end
            end else begin
               bitcnt_d = bitcnt_q - 1'b1;
            end
         end
         S_PAR: begin
            state_d  = post_frame;
            gapcnt_d = GAP_LD;
            done_d   = 1'b1;
         end
         S_GAP: begin
            if (gapcnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               gapcnt_d = gapcnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are computed from next state so they launch on the same edge.
   always_comb begin
      sout_d = 1'b0;
      sfr_d  = 1'b0;
      sen_d  = 1'b0;
      if (state_d == S_SHIFT) begin
         sout_d = shreg_d[WIDTH-1];
         sfr_d  = (bitcnt_d == LAST);
         sen_d  = 1'b1;
      end else if (state_d == S_PAR) begin
         sout_d = par_d;
         sen_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         gapcnt_q <= '0;
         par_q    <= 1'b0;
         sout_q   <= 1'b0;
         sfr_q    <= 1'b0;
         sen_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         gapcnt_q <= gapcnt_d;
         par_q    <= par_d;
         sout_q   <= sout_d;
         sfr_q    <= sfr_d;
         sen_q    <= sen_d;
         done_q   <= done_d;
      end
   end

   assign tx_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign ser_out   = sout_q;
   assign ser_frame = sfr_q;
   assign ser_en    = sen_q;
   assign done      = done_q;

endmodule

// File: tb/tb_search_latch_tx.sv
// Bench for search_latch_tx: three parameter sets share one clock and reset.
// Expected serial bits are queued at handshake and popped as ser_en cycles appear.
module tb_search_latch_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] txd [3];
   logic [2:0] txv;
   logic [2:0] rdy, sout, sfr, sen, bsy, dn;
   int         tests = 0;
   int         fails = 0;
   logic       q[$];

   always #5 clk = ~clk;

   search_latch_tx #(.WIDTH(8), .PARITY_EN(1'b1), .GAP(1)) u0 (
      .clk(clk), .rst_n(rst_n), .tx_data(txd[0]), .tx_valid(txv[0]),
      .tx_ready(rdy[0]), .ser_out(sout[0]), .ser_frame(sfr[0]),
      .ser_en(sen[0]), .busy(bsy[0]), .done(dn[0]));

   search_latch_tx #(.WIDTH(8), .PARITY_EN(1'b0), .GAP(1)) u1 (
      .clk(clk), .rst_n(rst_n), .tx_data(txd[1]), .tx_valid(txv[1]),
      .tx_ready(rdy[1]), .ser_out(sout[1]), .ser_frame(sfr[1]),
      .ser_en(sen[1]), .busy(bsy[1]), .done(dn[1]));

   search_latch_tx #(.WIDTH(8), .PARITY_EN(1'b1), .GAP(0)) u2 (
      .clk(clk), .rst_n(rst_n), .tx_data(txd[2]), .tx_valid(txv[2]),
      .tx_ready(rdy[2]), .ser_out(sout[2]), .ser_frame(sfr[2]),
      .ser_en(sen[2]), .busy(bsy[2]), .done(dn[2]));

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      rst_n = 1'b0;
      txv   = '0;
      for (int k = 0; k < 3; k++) txd[k] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({sout, sfr, sen, bsy, dn} !== '0 || rdy !== 3'b111) begin
         fails++;
         $display("FAIL reset_hold: outs=%b rdy=%b want 0/111",
                  {sout, sfr, sen, bsy, dn}, rdy);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests++;
         if ({sout, sfr, sen, bsy, dn} !== '0 || rdy !== 3'b111) begin
            fails++;
            $display("FAIL reset_idle c%0d: outs=%b rdy=%b want 0/111",
                     c, {sout, sfr, sen, bsy, dn}, rdy);
         end
      end
   endtask

   task automatic run_frame(input int k, input logic [7:0] d,
                            input bit pe, input int gap, input bit mangle);
      int  n, last, dcyc, dcnt, lo;
      logic exp;
      n = 0; last = -1; dcyc = -1; dcnt = 0; lo = 0;
      q.delete();
      @(posedge clk); #1;
      txd[k] = d;
      txv[k] = 1'b1;
      for (int i = 7; i >= 0; i--) q.push_back(d[i]);
      if (pe) q.push_back(^d);
      @(posedge clk); #1;
      txv[k] = mangle;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mangle && c < 7) begin
            txd[k] = 8'($urandom);
            txv[k] = 1'($urandom_range(0, 1));
         end else if (mangle && c == 7) begin
            txv[k] = 1'b0;
         end
         if (!rdy[k]) lo++;
         if (sen[k]) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL extra_bit u%0d c%0d: ser_en=1 want 0", k, c);
            end else begin
               exp = q.pop_front();
               if (sout[k] !== exp) begin
                  fails++;
                  $display("FAIL bit u%0d c%0d: got %b want %b",
                           k, c, sout[k], exp);
               end
            end
            tests++;
            if (sfr[k] !== (n == 0)) begin
               fails++;
               $display("FAIL frame u%0d c%0d: got %b want %b",
                        k, c, sfr[k], (n == 0));
            end
            n++;
            last = c;
         end
         if (dn[k] === 1'b1) begin
            dcnt++;
            if (dcyc < 0) dcyc = c;
         end
      end
      tests++;
      if (n != 8 + int'(pe)) begin
         fails++;
         $display("FAIL length u%0d: got %0d want %0d", k, n, 8 + int'(pe));
      end
      tests++;
      if (dcnt != 1 || dcyc != last + 1) begin
         fails++;
         $display("FAIL done u%0d: cnt %0d at %0d want 1 at %0d",
                  k, dcnt, dcyc, last + 1);
      end
      tests++;
      if (lo != 8 + int'(pe) + gap) begin
         fails++;
         $display("FAIL ready_low u%0d: got %0d want %0d",
                  k, lo, 8 + int'(pe) + gap);
      end
   endtask

   task automatic test_single();
      run_frame(0, 8'hA5, 1'b1, 1, 1'b0);
   endtask

   task automatic test_odd();
      run_frame(0, 8'h07, 1'b1, 1, 1'b0);
      run_frame(1, 8'h07, 1'b0, 1, 1'b0);
   endtask

   task automatic test_back_to_back();
      int   f1, f2, idle_between, n;
      logic exp;
      f1 = -1; f2 = -1; idle_between = 0; n = 0;
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back(1'b1);
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(1'b0);
      q.push_back(1'b0);
      @(posedge clk); #1;
      txd[2] = 8'hFF;
      txv[2] = 1'b1;
      @(posedge clk); #1;
      txd[2] = 8'h00;
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         if (sfr[2]) begin
            if (f1 < 0) f1 = c;
            else if (f2 < 0) begin
               f2 = c;
               txv[2] = 1'b0;
            end
         end
         if (f1 >= 0 && f2 < 0 && !sen[2]) idle_between++;
         if (sen[2]) begin
            n++;
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL b2b_extra c%0d: ser_en=1 want 0", c);
            end else begin
               exp = q.pop_front();
               if (sout[2] !== exp) begin
                  fails++;
                  $display("FAIL b2b_bit c%0d: got %b want %b",
                           c, sout[2], exp);
               end
            end
         end
      end
      txv[2] = 1'b0;
      tests++;
      if (f1 < 0 || f2 - f1 != 10) begin
         fails++;
         $display("FAIL b2b_spacing: frames at %0d,%0d want 10 apart", f1, f2);
      end
      tests++;
      if (idle_between != 1) begin
         fails++;
         $display("FAIL b2b_gap: got %0d idle want 1", idle_between);
      end
      tests++;
      if (n != 18) begin
         fails++;
         $display("FAIL b2b_count: got %0d en want 18", n);
      end
   endtask

   task automatic test_midreset();
      int en_cnt, lo, dcnt;
      en_cnt = 0; lo = 0; dcnt = 0;
      @(posedge clk); #1;
      txd[0] = 8'hF0;
      txv[0] = 1'b1;
      @(posedge clk); #1;
      txv[0] = 1'b0;
      repeat (4) @(negedge clk);
      tests++;
      if (sen[0] !== 1'b1 || sout[0] !== 1'b1) begin
         fails++;
         $display("FAIL mid_pre: en=%b out=%b want 1/1", sen[0], sout[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({sen[0], bsy[0], sout[0], sfr[0]} !== 4'b0000) begin
         fails++;
         $display("FAIL mid_async: en/busy/out/fr=%b want 0000",
                  {sen[0], bsy[0], sout[0], sfr[0]});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (sen[0]) en_cnt++;
         if (!rdy[0]) lo++;
         if (dn[0]) dcnt++;
      end
      tests++;
      if (en_cnt != 0 || lo != 0 || dcnt != 0) begin
         fails++;
         $display("FAIL mid_resume: en %0d notready %0d done %0d want 0",
                  en_cnt, lo, dcnt);
      end
   endtask

   task automatic test_ignored();
      run_frame(0, 8'h3C, 1'b1, 1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_single();
      test_odd();
      test_back_to_back();
      test_midreset();
      test_ignored();
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
